bcd_count_7seg: RTL

- Two-digit decimal up/down counter with a built-in prescaler and a registered 7-segment encoder.
- Produces the packed 14-bit pattern pair consumed by the downstream two-digit display multiplexer: tens digit in [13:7], ones digit in [6:0].
- Sits between event/control logic and the display driver. Lets the board show a 00–99 count stepped at a prescaled rate.

---
 rtl/bcd_count_7seg.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/bcd_count_7seg.sv
// -----------------------------------------------------------------------------
// bcd_count_7seg
//
// Two-digit decimal (00..99) up/down counter stepped by an internal prescaler,
// followed by a registered 7-segment encoder that feeds the two-digit display
// multiplexer.
//
// Parameters:
//   TICK_DIV  clk cycles per count step (>= 2)
//   CBITS     prescaler width, 2**CBITS > TICK_DIV
//
// Ports:
//   clk       in   1   system clock, rising edge
//   rst       in   1   asynchronous active-high reset
//   en        in   1   count enable; prescaler advances only while high
//   up        in   1   direction, 1 = increment, 0 = decrement
//   load      in   1   synchronous load strobe (beats tick and en)
//   load_val  in   8   BCD load value, [7:4] tens, [3:0] ones
//   bcd       out  8   current count in BCD
//   both7seg  out  14  segment patterns, [13:7] tens, [6:0] ones (g..a)
//   wrap      out  1   one-cycle pulse on 99->00 (up) or 00->99 (down)
// -----------------------------------------------------------------------------
module bcd_count_7seg #(
    parameter int TICK_DIV = 20000,
    parameter int CBITS    = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        up,
    input  logic        load,
    input  logic [7:0]  load_val,
    output logic [7:0]  bcd,
    output logic [13:0] both7seg,
    output logic        wrap
);

    localparam logic [CBITS-1:0] CNT_LAST = CBITS'(TICK_DIV - 1);
    localparam logic [CBITS-1:0] CNT_ONE  = CBITS'(1);
    localparam logic [CBITS-1:0] CNT_ZERO = {CBITS{1'b0}};

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Active-high segment pattern, bit6 = g ... bit0 = a. Non-decimal codes
    // blank the digit so a corrupted value can never show a bogus glyph.
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'h3F;
            4'd1:    pattern = 7'h06;
            4'd2:    pattern = 7'h5B;
            4'd3:    pattern = 7'h4F;
            4'd4:    pattern = 7'h66;
            4'd5:    pattern = 7'h6D;
            4'd6:    pattern = 7'h7D;
            4'd7:    pattern = 7'h07;
            4'd8:    pattern = 7'h7F;
            4'd9:    pattern = 7'h6F;
            default: pattern = 7'h00;
        endcase
        return pattern;
    endfunction

    // Loaded digits above 9 are forced to 0 so bcd always stays decimal.
    function automatic logic [3:0] sanitize(input logic [3:0] digit);
        logic [3:0] clean;
        if (digit > 4'd9) begin
            clean = 4'd0;
        end else begin
            clean = digit;
        end
        return clean;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [CBITS-1:0] cnt_q;
    logic [CBITS-1:0] cnt_d;
    logic [7:0]       bcd_q;
    logic [7:0]       bcd_d;
    logic [13:0]      seg_q;
    logic [13:0]      seg_d;
    logic             wrap_q;
    logic             wrap_d;

    logic             tick_s;
    logic [3:0]       ones_s;
    logic [3:0]       tens_s;
    logic [3:0]       ones_n_s;
    logic [3:0]       tens_n_s;

    assign ones_s = bcd_q[3:0];
    assign tens_s = bcd_q[7:4];

    // Prescaler: load clears it, en advances it, terminal count is the tick.
    always_comb begin
        cnt_d  = cnt_q;
        tick_s = 1'b0;
        if (load) begin
            cnt_d = CNT_ZERO;
        end else if (en) begin
            if (cnt_q >= CNT_LAST) begin
                // >= also recovers from any out-of-range prescaler value
                cnt_d  = CNT_ZERO;
                tick_s = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // BCD step: carry/borrow between digits, wrap flagged on the full roll-over.
    always_comb begin
        ones_n_s = ones_s;
        tens_n_s = tens_s;
        wrap_d   = 1'b0;
        if (load) begin
            // Load discards any coincident step and never wraps.
            tens_n_s = sanitize(load_val[7:4]);
            ones_n_s = sanitize(load_val[3:0]);
        end else if (tick_s) begin
            if (up) begin
                if (ones_s >= 4'd9) begin
                    ones_n_s = 4'd0;
                    if (tens_s >= 4'd9) begin
                        tens_n_s = 4'd0;
                        wrap_d   = 1'b1;
                    end else begin
                        tens_n_s = tens_s + 4'd1;
                    end
                end else begin
                    ones_n_s = ones_s + 4'd1;
                end
            end else begin
                if ((ones_s == 4'd0) || (ones_s > 4'd9)) begin
                    ones_n_s = 4'd9;
                    if ((tens_s == 4'd0) || (tens_s > 4'd9)) begin
                        tens_n_s = 4'd9;
                        wrap_d   = 1'b1;
                    end else begin
                        tens_n_s = tens_s - 4'd1;
                    end
                end else begin
                    ones_n_s = ones_s - 4'd1;
                end
            end
        end else begin
            ones_n_s = ones_s;
            tens_n_s = tens_s;
        end
        bcd_d = {tens_n_s, ones_n_s};
    end

    // Encoder input is the registered count, so both7seg trails bcd by a cycle.
    always_comb begin
        seg_d = {seg7(tens_s), seg7(ones_s)};
    end

    // All state registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= CNT_ZERO;
            bcd_q  <= 8'h00;
            seg_q  <= 14'h0000;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bcd_q  <= bcd_d;
            seg_q  <= seg_d;
            wrap_q <= wrap_d;
        end
    end

    assign bcd      = bcd_q;
    assign both7seg = seg_q;
    assign wrap     = wrap_q;

endmodule
